// File: rtl/rob_pkg.sv
// Shared types and default sizes for the reorder buffer.
package rob_pkg;

  localparam int unsigned DefRobDepth     = 8;
  localparam int unsigned DefGprAddrWidth = 5;
  localparam int unsigned DefDataWidth    = 32;
  localparam int unsigned TW              = $clog2(DefRobDepth);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StWait  = 2'd1,
    StDone  = 2'd2
  } rob_state_e;

  typedef struct packed {
    rob_state_e                 state;
    logic [DefGprAddrWidth-1:0] dst_addr;
    logic                       dst_wen;
    logic [DefDataWidth-1:0]    data;
    logic                       br_taken;
    logic [DefDataWidth-1:0]    br_target;
    logic                       exp;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit ring pointer with equality / full compare against a peer pointer.
module rob_ptr #(
  parameter int unsigned TagW = rob_pkg::TW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [TagW:0] other_ptr,
  output logic [TagW:0] ptr,
  output logic          same,
  output logic          opposite
);

  logic [TagW:0] ptr_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  assign ptr      = ptr_q;
  assign same     = (ptr_q == other_ptr);
  assign opposite = (ptr_q[TagW-1:0] == other_ptr[TagW-1:0]) &&
                    (ptr_q[TagW] != other_ptr[TagW]);

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order single-entry retire.
module rob
  import rob_pkg::*;
#(
  parameter int unsigned ROB_DEPTH      = DefRobDepth,
  parameter int unsigned GPR_ADDR_WIDTH = DefGprAddrWidth,
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  localparam int unsigned TagW          = $clog2(ROB_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_req,
  input  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
  input  logic                      alloc_dst_wen,
  output logic                      alloc_ready,
  output logic                      allocate_en,
  output logic [TagW-1:0]           rob_alloc_tag_2rat,
  output logic [GPR_ADDR_WIDTH-1:0] rob_alloc_dst_addr_2rat,
  output logic                      rob_alloc_dst_wen_2rat,
  input  logic                      wb_en,
  input  logic [TagW-1:0]           wb_tag,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      wb_br_taken,
  input  logic [DATA_WIDTH-1:0]     wb_br_target,
  input  logic                      wb_exp,
  input  logic [TagW-1:0]           rd1_tag,
  input  logic [TagW-1:0]           rd2_tag,
  output logic                      rd1_ready,
  output logic                      rd2_ready,
  output logic [DATA_WIDTH-1:0]     rd1_data,
  output logic [DATA_WIDTH-1:0]     rd2_data,
  output logic                      commit_dst_en,
  output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr_2rat,
  output logic [TagW-1:0]           rob_commit_Paddr,
  output logic [DATA_WIDTH-1:0]     commit_data,
  output logic                      rob_commit_br_taken,
  output logic                      rob_commit_exp_en,
  output logic [DATA_WIDTH-1:0]     commit_redirect_pc
);

  // Entry field widths follow the package defaults.
  rob_entry_t entries_q [ROB_DEPTH];

  logic [TagW:0]   head_ptr, tail_ptr;
  logic            head_same, head_opp, tail_same, tail_opp;
  logic            empty, full, commit_fire, flush;
  logic [TagW-1:0] head_idx, tail_idx;
  rob_entry_t      head_e, rd1_e, rd2_e;
  logic            rd1_byp, rd2_byp;

  rob_ptr #(.TagW(TagW)) u_head_ptr (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .inc      (commit_fire),
    .other_ptr(tail_ptr),
    .ptr      (head_ptr),
    .same     (head_same),
    .opposite (head_opp)
  );

  rob_ptr #(.TagW(TagW)) u_tail_ptr (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .inc      (allocate_en),
    .other_ptr(head_ptr),
    .ptr      (tail_ptr),
    .same     (tail_same),
    .opposite (tail_opp)
  );

  // Both compares are symmetric, so either instance's view gives the same answer.
  assign empty    = head_same & tail_same;
  assign full     = head_opp & tail_opp;
  assign head_idx = head_ptr[TagW-1:0];
  assign tail_idx = tail_ptr[TagW-1:0];
  assign head_e   = entries_q[head_idx];

  assign commit_fire = !empty && (head_e.state == StDone);
  assign flush       = commit_fire && (head_e.br_taken || head_e.exp);
  assign alloc_ready = !full && !flush;
  assign allocate_en = alloc_req && alloc_ready;

  assign rob_alloc_tag_2rat      = tail_idx;
  assign rob_alloc_dst_addr_2rat = alloc_dst_addr;
  assign rob_alloc_dst_wen_2rat  = alloc_dst_wen;

  // Same-cycle bypass only for entries still awaiting their result.
  assign rd1_e     = entries_q[rd1_tag];
  assign rd2_e     = entries_q[rd2_tag];
  assign rd1_byp   = wb_en && (wb_tag == rd1_tag) && (rd1_e.state == StWait);
  assign rd2_byp   = wb_en && (wb_tag == rd2_tag) && (rd2_e.state == StWait);
  assign rd1_ready = rd1_byp || (rd1_e.state == StDone);
  assign rd2_ready = rd2_byp || (rd2_e.state == StDone);
  assign rd1_data  = rd1_byp ? wb_data : rd1_e.data;
  assign rd2_data  = rd2_byp ? wb_data : rd2_e.data;

  assign commit_dst_en            = commit_fire && !head_e.exp && head_e.dst_wen;
  assign rob_commit_exp_en        = commit_fire && head_e.exp;
  assign rob_commit_br_taken      = commit_fire && !head_e.exp && head_e.br_taken;
  assign rob_commit_dst_addr_2rat = commit_fire ? head_e.dst_addr : '0;
  assign rob_commit_Paddr         = head_idx;
  assign commit_data              = commit_fire ? head_e.data : '0;
  assign commit_redirect_pc       = (commit_fire && !head_e.exp) ? head_e.br_target : '0;

  // Alloc slot, wb slot and head never collide: tail is EMPTY when not full, head is DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ROB_DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < int'(ROB_DEPTH); i++) begin
        entries_q[i].state <= StEmpty;
      end
    end else begin
      if (allocate_en) begin
        entries_q[tail_idx].state     <= StWait;
        entries_q[tail_idx].dst_addr  <= alloc_dst_addr;
        entries_q[tail_idx].dst_wen   <= alloc_dst_wen;
        entries_q[tail_idx].data      <= '0;
        entries_q[tail_idx].br_taken  <= 1'b0;
        entries_q[tail_idx].br_target <= '0;
        entries_q[tail_idx].exp       <= 1'b0;
      end
      if (wb_en && (entries_q[wb_tag].state == StWait)) begin
        entries_q[wb_tag].state     <= StDone;
        entries_q[wb_tag].data      <= wb_data;
        entries_q[wb_tag].br_taken  <= wb_br_taken;
        entries_q[wb_tag].br_target <= wb_br_target;
        entries_q[wb_tag].exp       <= wb_exp;
      end
      if (commit_fire) begin
        entries_q[head_idx].state <= StEmpty;
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: expected retirements are queued at allocate/writeback time.
module tb_rob;

  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_req, alloc_dst_wen, alloc_ready, allocate_en;
  logic [4:0]  alloc_dst_addr, rob_alloc_dst_addr_2rat, rob_commit_dst_addr_2rat;
  logic [2:0]  rob_alloc_tag_2rat, wb_tag, rd1_tag, rd2_tag, rob_commit_Paddr;
  logic        rob_alloc_dst_wen_2rat;
  logic        wb_en, wb_br_taken, wb_exp;
  logic [31:0] wb_data, wb_br_target, rd1_data, rd2_data, commit_data, commit_redirect_pc;
  logic        rd1_ready, rd2_ready, commit_dst_en, rob_commit_br_taken, rob_commit_exp_en;

  always #5 clk = ~clk;

  rob u_dut (
    .clk                     (clk),
    .rst                     (rst),
    .alloc_req               (alloc_req),
    .alloc_dst_addr          (alloc_dst_addr),
    .alloc_dst_wen           (alloc_dst_wen),
    .alloc_ready             (alloc_ready),
    .allocate_en             (allocate_en),
    .rob_alloc_tag_2rat      (rob_alloc_tag_2rat),
    .rob_alloc_dst_addr_2rat (rob_alloc_dst_addr_2rat),
    .rob_alloc_dst_wen_2rat  (rob_alloc_dst_wen_2rat),
    .wb_en                   (wb_en),
    .wb_tag                  (wb_tag),
    .wb_data                 (wb_data),
    .wb_br_taken             (wb_br_taken),
    .wb_br_target            (wb_br_target),
    .wb_exp                  (wb_exp),
    .rd1_tag                 (rd1_tag),
    .rd2_tag                 (rd2_tag),
    .rd1_ready               (rd1_ready),
    .rd2_ready               (rd2_ready),
    .rd1_data                (rd1_data),
    .rd2_data                (rd2_data),
    .commit_dst_en           (commit_dst_en),
    .rob_commit_dst_addr_2rat(rob_commit_dst_addr_2rat),
    .rob_commit_Paddr        (rob_commit_Paddr),
    .commit_data             (commit_data),
    .rob_commit_br_taken     (rob_commit_br_taken),
    .rob_commit_exp_en       (rob_commit_exp_en),
    .commit_redirect_pc      (commit_redirect_pc)
  );

  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  dst;
    logic        wen;
    logic        done;
    logic [31:0] data;
    logic        br;
    logic [31:0] tgt;
    logic        ex;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned model_tail = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Retirement monitor: every visible commit must match the oldest queued entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (commit_dst_en || rob_commit_exp_en || rob_commit_br_taken)) begin
      if (sb_q.size() == 0) begin
        check_eq("commit_unexpected", {29'd0, commit_dst_en, rob_commit_exp_en,
                 rob_commit_br_taken}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("commit_tag", rob_commit_Paddr, e.tag);
        if (e.ex) begin
          check_eq("commit_exp_en", rob_commit_exp_en, 1);
          check_eq("commit_exp_dst_en", commit_dst_en, 0);
        end else begin
          check_eq("commit_exp_en_idle", rob_commit_exp_en, 0);
          check_eq("commit_dst_en", commit_dst_en, e.wen);
          check_eq("commit_dst_addr", rob_commit_dst_addr_2rat, e.dst);
          check_eq("commit_data", commit_data, e.data);
          check_eq("commit_br_taken", rob_commit_br_taken, e.br);
          if (e.br) check_eq("commit_redirect_pc", commit_redirect_pc, e.tgt);
        end
        if (e.ex || e.br) begin
          sb_q.delete();
          model_tail = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_req = 0; alloc_dst_addr = 0; alloc_dst_wen = 0;
    wb_en = 0; wb_tag = 0; wb_data = 0; wb_br_taken = 0; wb_br_target = 0; wb_exp = 0;
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete();
    model_tail = 0;
  endtask

  task automatic do_alloc(input logic [4:0] dst, input logic wen);
    exp_t e;
    logic can;
    alloc_req = 1'b1; alloc_dst_addr = dst; alloc_dst_wen = wen;
    can = (sb_q.size() < Depth);
    #1;
    check_eq("alloc_ready", alloc_ready, can);
    check_eq("alloc_en", allocate_en, can);
    check_eq("alloc_tag", rob_alloc_tag_2rat, model_tail[2:0]);
    check_eq("alloc_dst", rob_alloc_dst_addr_2rat, dst);
    check_eq("alloc_wen", rob_alloc_dst_wen_2rat, wen);
    if (can) begin
      e = '{tag: model_tail[2:0], dst: dst, wen: wen, done: 0, data: 0, br: 0, tgt: 0, ex: 0};
      sb_q.push_back(e);
      model_tail = (model_tail + 1) % Depth;
    end
    @(posedge clk);
    #1;
    alloc_req = 1'b0;
  endtask

  task automatic do_wb(input logic [2:0] tag, input logic [31:0] data, input logic br,
                       input logic [31:0] tgt, input logic ex);
    int idx;
    wb_en = 1'b1; wb_tag = tag; wb_data = data;
    wb_br_taken = br; wb_br_target = tgt; wb_exp = ex;
    rd2_tag = tag;
    idx = -1;
    foreach (sb_q[k]) if (sb_q[k].tag == tag && !sb_q[k].done) idx = k;
    #1;
    if (idx >= 0) begin
      check_eq("rd2_bypass_ready", rd2_ready, 1);
      check_eq("rd2_bypass_data", rd2_data, data);
    end
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    foreach (sb_q[k]) begin
      if (sb_q[k].tag == tag && !sb_q[k].done) begin
        sb_q[k].done = 1; sb_q[k].data = data; sb_q[k].br = br;
        sb_q[k].tgt = tgt; sb_q[k].ex = ex;
      end
    end
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && sb_q.size() != 0; i++) tick();
    check_eq("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    logic [2:0] tags[$];
    logic [2:0] tag_a, tag_b;
    rd1_tag = 0; rd2_tag = 0;
    do_reset();

    // Reset state
    check_eq("rst_alloc_ready", alloc_ready, 1);
    check_eq("rst_alloc_tag", rob_alloc_tag_2rat, 0);
    check_eq("rst_commit_dst_en", commit_dst_en, 0);
    check_eq("rst_commit_exp", rob_commit_exp_en, 0);
    check_eq("rst_commit_br", rob_commit_br_taken, 0);
    check_eq("rst_commit_data", commit_data, 0);
    check_eq("rst_commit_paddr", rob_commit_Paddr, 0);
    check_eq("rst_rd1_ready", rd1_ready, 0);

    // 1: three allocations
    do_alloc(5'd1, 1'b1);
    do_alloc(5'd2, 1'b1);
    do_alloc(5'd3, 1'b1);
    rd1_tag = 3'd1;
    #1;
    check_eq("t1_rd1_wait", rd1_ready, 0);

    // 2: out-of-order writeback, in-order retire
    do_wb(3'd2, 32'hA, 0, 0, 0);
    rd1_tag = 3'd2;
    #1;
    check_eq("t2_rd1_stored_ready", rd1_ready, 1);
    check_eq("t2_rd1_stored_data", rd1_data, 32'hA);
    check_eq("t2_no_commit_yet", commit_dst_en, 0);
    do_wb(3'd0, 32'hC, 0, 0, 0);
    check_eq("t2_commit0_en", commit_dst_en, 1);
    check_eq("t2_commit0_paddr", rob_commit_Paddr, 0);
    check_eq("t2_commit0_data", commit_data, 32'hC);
    tick();
    check_eq("t2_tag1_blocks", commit_dst_en, 0);
    do_wb(3'd1, 32'hB, 0, 0, 0);
    tick();
    check_eq("t2_commit2_paddr", rob_commit_Paddr, 2);
    check_eq("t2_commit2_data", commit_data, 32'hA);
    wait_drain(4);

    // 3: fill to full, free one slot, wrap through tag 7 -> 0
    for (int i = 0; i < 8; i++) do_alloc(5'(i + 4), 1'b1);
    check_eq("t3_full_ready", alloc_ready, 0);
    alloc_req = 1'b1;
    #1;
    check_eq("t3_full_no_alloc", allocate_en, 0);
    alloc_req = 1'b0;
    do_wb(sb_q[0].tag, 32'h300, 0, 0, 0);
    check_eq("t3_commit_while_full", commit_dst_en, 1);
    check_eq("t3_no_full_bypass", alloc_ready, 0);
    tick();
    check_eq("t3_ready_after_commit", alloc_ready, 1);
    do_alloc(5'd20, 1'b1);
    tags.delete();
    foreach (sb_q[k]) tags.push_back(sb_q[k].tag);
    foreach (tags[k]) do_wb(tags[k], 32'h400 + 32'(k), 0, 0, 0);
    wait_drain(6);

    // 4: taken branch flush
    tag_a = model_tail[2:0];
    do_alloc(5'd5, 1'b1);
    tag_b = model_tail[2:0];
    do_alloc(5'd6, 1'b1);
    do_wb(tag_a, 32'h55, 1, 32'h100, 0);
    check_eq("t4_br_taken", rob_commit_br_taken, 1);
    check_eq("t4_redirect", commit_redirect_pc, 32'h100);
    alloc_req = 1'b1; alloc_dst_addr = 5'd9;
    wb_en = 1'b1; wb_tag = tag_b; wb_data = 32'h66; wb_br_taken = 0; wb_exp = 0;
    #1;
    check_eq("t4_flush_ready", alloc_ready, 0);
    check_eq("t4_flush_no_alloc", allocate_en, 0);
    tick();
    alloc_req = 1'b0; wb_en = 1'b0;
    rd1_tag = tag_b;
    #1;
    check_eq("t4_after_br", rob_commit_br_taken, 0);
    check_eq("t4_after_dst_en", commit_dst_en, 0);
    check_eq("t4_tail_zero", rob_alloc_tag_2rat, 0);
    check_eq("t4_after_ready", alloc_ready, 1);
    check_eq("t4_wb_discarded", rd1_ready, 0);

    // 5: exception at head
    do_alloc(5'd7, 1'b1);
    do_alloc(5'd8, 1'b1);
    do_wb(3'd0, 32'h77, 0, 0, 1);
    check_eq("t5_exp_en", rob_commit_exp_en, 1);
    check_eq("t5_exp_no_dst", commit_dst_en, 0);
    tick();
    rd1_tag = 3'd1;
    #1;
    check_eq("t5_after_exp", rob_commit_exp_en, 0);
    check_eq("t5_after_ready", alloc_ready, 1);
    check_eq("t5_tail_zero", rob_alloc_tag_2rat, 0);
    check_eq("t5_flushed_entry", rd1_ready, 0);

    // 6: reset with entries in flight
    for (int i = 0; i < 5; i++) do_alloc(5'(10 + i), 1'b1);
    do_wb(3'd1, 32'h11, 0, 0, 0);
    do_wb(3'd2, 32'h22, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    model_tail = 0;
    rd1_tag = 3'd1; rd2_tag = 3'd2;
    #1;
    check_eq("t6_commit_dst_en", commit_dst_en, 0);
    check_eq("t6_commit_exp", rob_commit_exp_en, 0);
    check_eq("t6_commit_br", rob_commit_br_taken, 0);
    check_eq("t6_ready", alloc_ready, 1);
    check_eq("t6_tail_zero", rob_alloc_tag_2rat, 0);
    check_eq("t6_rd1_cleared", rd1_ready, 0);
    check_eq("t6_rd2_cleared", rd2_ready, 0);
    do_alloc(5'd3, 1'b1);
    do_wb(3'd0, 32'h99, 0, 0, 0);
    wait_drain(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob.md
Name: rob

Overview:
Reorder buffer between dispatch and the register alias table.
- Allocates one in-order tag per dispatched instruction and drives the RAT allocate interface.
- Captures execution results and offers operand-forwarding reads to the issue stage.
- Retires in order, one entry per cycle, driving the RAT commit, branch-flush and exception interfaces.

Parameters:
ROB_DEPTH, 8, number of entries; must be a power of 2; tag width TW = $clog2(ROB_DEPTH).
GPR_ADDR_WIDTH, 5, architectural register address width.
DATA_WIDTH, 32, result and branch-target width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
alloc_req  in  1  dispatch requests one entry.
alloc_dst_addr  in  GPR_ADDR_WIDTH  destination architectural register.
alloc_dst_wen  in  1  instruction writes its destination.
alloc_ready  out  1  entry available (not full, no flush pending).
allocate_en  out  1  alloc_req & alloc_ready.
rob_alloc_tag_2rat / rob_alloc_dst_addr_2rat / rob_alloc_dst_wen_2rat  out  TW/GPR_ADDR_WIDTH/1  tail tag plus pass-through of the alloc fields.
wb_en  in  1  execution result valid.
wb_tag  in  TW  entry being written back.
wb_data  in  DATA_WIDTH  result.
wb_br_taken  in  1  branch resolved as taken or mispredicted.
wb_br_target  in  DATA_WIDTH  redirect pc.
wb_exp  in  1  instruction raised an exception.
rd1_tag, rd2_tag  in  TW  operand lookup tags (from the RAT Paddr).
rd1_ready, rd2_ready  out  1  result available.
rd1_data, rd2_data  out  DATA_WIDTH  result value.
commit_dst_en  out  1  retire with GPR write.
rob_commit_dst_addr_2rat  out  GPR_ADDR_WIDTH  architectural destination.
rob_commit_Paddr  out  TW  head tag.
commit_data  out  DATA_WIDTH  value written to the GPR file.
rob_commit_br_taken  out  1  retiring taken branch; flush.
rob_commit_exp_en  out  1  retiring exception; flush.
commit_redirect_pc  out  DATA_WIDTH  target pc for the branch flush.

Behaviour:
- Storage and pointers
  - Per entry: state {EMPTY, WAIT, DONE}, dst_addr, dst_wen, data, br_taken, br_target, exp.
  - head_ptr and tail_ptr are TW+1 bits wide; the MSB is the wrap bit.
  - empty = ptrs equal; full = low bits equal and wrap bits differ.
- Reset (rst sampled high at a clock edge)
  - All entries are EMPTY and both pointers are 0.
  - Outputs after reset: alloc_ready=1; every commit_*, rd*_ready and rob_commit_* output = 0; tag outputs = 0.
- Allocate
  - Fires when alloc_req & alloc_ready.
  - The entry at tail becomes WAIT with its fields stored; tail increments at the clock edge.
  - The RAT outputs are combinational from tail and the alloc inputs in the same cycle.
  - alloc_ready = !full & !flush. It does not count a commit in the same cycle (no full-bypass).
- Writeback
  - wb_en writes data/br/exp into entry wb_tag and sets it DONE at the edge.
  - wb to an EMPTY or DONE entry is ignored.
- Operand read (combinational)
  - rdN_ready = entry DONE, or (wb_en & wb_tag==rdN_tag) as a same-cycle bypass.
  - rdN_data comes from the bypass when it hits, otherwise from the stored data.
  - rdN_ready = 0 for EMPTY entries.
- Commit (combinational from head; state updates at the edge)
  - Fires when the head entry is DONE and the buffer is not empty.
  - exp=1: rob_commit_exp_en=1 and commit_dst_en=0.
  - Otherwise: commit_dst_en = dst_wen, rob_commit_br_taken = br_taken, and commit_redirect_pc = br_target.
  - On commit the head entry becomes EMPTY and head increments.
  - A writeback to the head entry in cycle N makes it committable in cycle N+1. Commit never bypasses wb.
- Flush
  - flush = commit firing with br_taken or exp.
  - At that edge all entries become EMPTY and head = tail = 0; allocation in the same cycle is blocked.
  - Writebacks arriving in the flush cycle are discarded.
- Simultaneous events
  - alloc, wb and commit in one cycle are all honoured, including alloc into the slot freed by commit when not full.
  - Pointers wrap modulo 2·ROB_DEPTH through the natural overflow of the extra bit.
  - rst has priority over everything, mid-operation included.

Decomposition:
- A shared package holds:
  - the rob_state_e enum (EMPTY/WAIT/DONE);
  - the TW localparam derived from ROB_DEPTH;
  - the rob_entry_t struct.
- GPR_ADDR_WIDTH and ROB_DEPTH stay in the common defines.
- Optional sub-module rob_ptr: wrap-bit pointer plus the full/empty compare, instantiated for both head and tail.

Test Plan:
1. Reset, then allocate x3 (dst 1,2,3; wen=1) -> tags 0,1,2 driven to the RAT; alloc_ready stays 1; rd1_tag=1 gives rd1_ready=0.
2. Writebacks out of order (tag2 then tag0, data 0xA,0xC) -> rd1 bypass is ready in the wb cycle. Commit of tag0 (Paddr 0, data 0xC) occurs the cycle after its wb. Tag2 waits until tag1 is done.
3. Allocate 8 with no commit -> alloc_ready=0 after the eighth. A commit frees a slot, and alloc_ready=1 the next cycle. Wrap bit toggles after tag 7→0.
4. Entry with wb_br_taken=1 and target 0x100 reaches head -> rob_commit_br_taken=1 and commit_redirect_pc=0x100 for one cycle. The next cycle is empty, with tail=0 and alloc_ready=1. A concurrent alloc_req in the flush cycle is not accepted.
5. Head entry with wb_exp=1 and dst_wen=1 -> rob_commit_exp_en=1, commit_dst_en=0, flush.
6. rst asserted with 5 entries in flight -> next cycle empty and all commit outputs 0.
